// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder/subtractor.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width for N digits; at least one bit so N = 1 still has a register.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_digit.sv
// Combinational DIGIT-bit ripple adder; exposes the carry into its top bit for overflow.
module add_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_i,
  input  logic [DIGIT-1:0] b_i,
  input  logic             cin_i,
  output logic [DIGIT-1:0] s_o,
  output logic             cout_o,
  output logic             c_msb_o
);

  logic [DIGIT:0] c;

  assign c[0] = cin_i;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
    assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o  = c[DIGIT];
  assign c_msb_o = c[DIGIT-1];

endmodule

// File: rtl/serial_adder.sv
// Digit-serial add/subtract: one DIGIT-wide slice per RUN cycle, LSB digit first.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_width(N);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [DIGIT-1:0] dig_s;
  logic             dig_cout;
  logic             dig_cmsb;

  add_digit #(.DIGIT(DIGIT)) u_add_digit (
    .a_i     (a_q[DIGIT-1:0]),
    .b_i     (b_q[DIGIT-1:0]),
    .cin_i   (carry_q),
    .s_o     (dig_s),
    .cout_o  (dig_cout),
    .c_msb_o (dig_cmsb)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          // Subtraction folds into addition: invert b and the borrow-in once at capture.
          state_d = RUN;
          cnt_d   = '0;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = cin ^ sub;
          sum_d   = '0;
          cout_d  = 1'b0;
          ovf_d   = 1'b0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        a_d     = a_q >> DIGIT;
        b_d     = b_q >> DIGIT;
        sum_d   = (sum_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
        carry_d = dig_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) begin
          state_d = DONE;
          cnt_d   = '0;
          cout_d  = dig_cout;
          ovf_d   = dig_cmsb ^ dig_cout;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH=8 with DIGIT=1 and DIGIT=4 instances.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       sel;
  logic [7:0] a, b;
  logic       cin, sub;

  logic       start1, start4;
  logic       busy1, done1, cout1, ovf1;
  logic       busy4, done4, cout4, ovf4;
  logic [7:0] sum1, sum4;

  logic       busy_m, done_m, cout_m, ovf_m;
  logic [7:0] sum_m;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign start1 = start & ~sel;
  assign start4 = start & sel;

  assign busy_m = sel ? busy4 : busy1;
  assign done_m = sel ? done4 : done1;
  assign sum_m  = sel ? sum4  : sum1;
  assign cout_m = sel ? cout4 : cout1;
  assign ovf_m  = sel ? ovf4  : ovf1;

  serial_adder #(.WIDTH(8), .DIGIT(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  serial_adder #(.WIDTH(8), .DIGIT(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a), .b(b), .cin(cin), .sub(sub),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4), .ovf(ovf4)
  );

  typedef struct {
    logic       sel;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       sub;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Starts one operation, scrambles the inputs after the accepting edge, and
  // checks latency (edges counted including the accepting one) and result.
  task automatic run_op(input vec_t v, input string tag);
    int  edges;
    logic seen;
    @(negedge clk);
    sel = v.sel; a = v.a; b = v.b; cin = v.cin; sub = v.sub; start = 1'b1;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        start = 1'b0;
        a = ~v.a; b = v.a ^ v.b; cin = ~v.cin; sub = ~v.sub;
      end
      seen = done_m;
    end
    check({tag, " done_seen"}, 32'(seen), 32'd1);
    check({tag, " latency"}, 32'(edges), 32'(v.lat));
    check({tag, " sum"}, 32'(sum_m), 32'(v.sum));
    check({tag, " cout"}, 32'(cout_m), 32'(v.cout));
    check({tag, " ovf"}, 32'(ovf_m), 32'(v.ovf));
    @(posedge clk); #1;
    check({tag, " done_one_cycle"}, 32'(done_m), 32'd0);
    check({tag, " result_held"}, 32'(sum_m), 32'(v.sum));
  endtask

  initial begin
    int   edges;
    logic seen;
    int   ndone;

    //            sel  a      b      cin   sub   sum    cout  ovf  lat
    vecs[0] = '{1'b0, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 9};
    vecs[1] = '{1'b0, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 9};
    vecs[2] = '{1'b0, 8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0, 9};
    vecs[3] = '{1'b0, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 9};
    vecs[4] = '{1'b0, 8'h3C, 8'hC4, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 9};
    vecs[5] = '{1'b1, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 3};
    vecs[6] = '{1'b1, 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 3};
    vecs[7] = '{1'b1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 3};
    vecs[8] = '{1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 3};
    vecs[9] = '{1'b1, 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 3};

    rst = 1'b1; start = 1'b0; sel = 1'b0;
    a = 8'h00; b = 8'h00; cin = 1'b0; sub = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      #1;
      check($sformatf("reset%0d busy", s), 32'(busy_m), 32'd0);
      check($sformatf("reset%0d done", s), 32'(done_m), 32'd0);
      check($sformatf("reset%0d sum", s),  32'(sum_m),  32'd0);
      check($sformatf("reset%0d cout", s), 32'(cout_m), 32'd0);
      check($sformatf("reset%0d ovf", s),  32'(ovf_m),  32'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // Start pulsed mid-RUN with different operands must be ignored.
    @(negedge clk);
    sel = 1'b0; a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check("midstart busy", 32'(busy_m), 32'd1);
    a = 8'hFF; b = 8'hFF; cin = 1'b1; sub = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 4;
    seen  = 1'b0;
    while (!seen && edges < 20) begin
      @(posedge clk); #1;
      edges++;
      seen = done_m;
    end
    check("midstart latency", 32'(edges), 32'd9);
    check("midstart sum", 32'(sum_m), 32'h46);
    check("midstart cout", 32'(cout_m), 32'd0);
    check("midstart ovf", 32'(ovf_m), 32'd0);

    // Reset mid-RUN aborts with no done pulse.
    @(negedge clk);
    sel = 1'b0; a = 8'hAA; b = 8'h55; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort busy", 32'(busy_m), 32'd0);
    check("abort sum", 32'(sum_m), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int e = 0; e < 12; e++) begin
      @(posedge clk); #1;
      if (done_m) ndone++;
    end
    check("abort no_done", 32'(ndone), 32'd0);
    run_op(vecs[0], "after_abort");

    // Back-to-back: start held high across done.
    @(negedge clk);
    sel = 1'b0; a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    ndone = 0;
    for (int e = 1; e <= 22; e++) begin
      @(posedge clk); #1;
      if (done_m) ndone++;
      if (e == 9) begin
        check("b2b done1", 32'(done_m), 32'd1);
        check("b2b sum1", 32'(sum_m), 32'h03);
        a = 8'h20; b = 8'h03;
      end
      if (e == 10) check("b2b busy_again", 32'(busy_m), 32'd1);
      if (e == 18) begin
        check("b2b done2", 32'(done_m), 32'd1);
        check("b2b sum2", 32'(sum_m), 32'h23);
        start = 1'b0;
      end
    end
    check("b2b done_count", 32'(ndone), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
